// File: rtl/tppe_multi_neuron_candidate_engine.sv
// TPPE candidate front end: per-neuron spike histories, parallel weight-pattern intersection
// with thresholding, and hit serialisation into a FWFT candidate FIFO with full backpressure.
module tppe_multi_neuron_candidate_engine #(
    parameter int T_WINDOW        = 16,
    parameter int PARALLEL_FACTOR = 4,
    parameter int NUM_NEURONS     = 4,
    parameter int NEURON_ID_W     = 4,
    parameter int COL_ID_W        = 4,
    parameter int SCORE_W         = $clog2(T_WINDOW + 1),
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                spike_valid,
    input  logic [NUM_NEURONS-1:0]              spike_in,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [NEURON_ID_W-1:0]              req_neuron,
    input  logic [COL_ID_W-1:0]                 req_col_base,
    input  logic [PARALLEL_FACTOR*T_WINDOW-1:0] req_weights,
    input  logic [SCORE_W-1:0]                  req_thresh,
    output logic                                cand_valid,
    input  logic                                cand_ready,
    output logic [NEURON_ID_W-1:0]              cand_neuron,
    output logic [COL_ID_W-1:0]                 cand_col,
    output logic [SCORE_W-1:0]                  cand_score,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                err_neuron
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, EMIT} state_t;

    typedef struct packed {
        logic [NEURON_ID_W-1:0] neuron;
        logic [COL_ID_W-1:0]    col;
        logic [SCORE_W-1:0]     score;
    } cand_t;

    function automatic logic [SCORE_W-1:0] popcount(input logic [T_WINDOW-1:0] v);
        logic [SCORE_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < T_WINDOW; i++) acc = acc + SCORE_W'(v[i]);
        return acc;
    endfunction

    logic [T_WINDOW-1:0]    hist [NUM_NEURONS];
    state_t                 state_q, state_d;
    logic [NEURON_ID_W-1:0] neuron_q;
    logic [COL_ID_W-1:0]    base_q;
    logic [SCORE_W-1:0]     score_q [PARALLEL_FACTOR];
    logic [PARALLEL_FACTOR-1:0] mask_q;

    logic [T_WINDOW-1:0]    sel_hist;
    logic                   in_range;
    logic [SCORE_W-1:0]     lane_score [PARALLEL_FACTOR];
    logic [PARALLEL_FACTOR-1:0] lane_mask;

    logic                   accept, push, pop, full, emit_found;
    cand_t                  emit_entry;
    logic [PARALLEL_FACTOR-1:0] mask_clr;

    cand_t                  mem [FIFO_DEPTH];
    cand_t                  head;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid & req_ready;
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign push      = (state_q == EMIT) && emit_found && !full;
    assign cand_valid = (count != '0);
    assign pop       = cand_valid & cand_ready;

    // Out-of-range ids match no history row, so they read as all-zero.
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        sel_hist = '0;
        in_range = 1'b0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            if (req_neuron == NEURON_ID_W'(n)) begin
                sel_hist = hist[n];
                in_range = 1'b1;
            end
        end
        for (int j = 0; j < PARALLEL_FACTOR; j++) begin
            lane_score[j] = popcount(sel_hist & req_weights[j*T_WINDOW +: T_WINDOW]);
            lane_mask[j]  = (lane_score[j] >= req_thresh);
        end
    end

    // Lowest pending lane goes first; column wraps naturally in COL_ID_W bits.
    always_comb begin
        emit_found = 1'b0;
        emit_entry = '0;
        mask_clr   = mask_q;
        for (int j = 0; j < PARALLEL_FACTOR; j++) begin
            if (!emit_found && mask_q[j]) begin
                emit_found        = 1'b1;
                emit_entry.neuron = neuron_q;
                emit_entry.col    = base_q + COL_ID_W'(j);
                emit_entry.score  = score_q[j];
                mask_clr[j]       = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && lane_mask != '0) state_d = EMIT;
            EMIT:    if (push && mask_clr == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            neuron_q   <= '0;
            base_q     <= '0;
            mask_q     <= '0;
            err_neuron <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) hist[n] <= '0;
            for (int j = 0; j < PARALLEL_FACTOR; j++) score_q[j] <= '0;
        end else begin
            state_q <= state_d;
            if (spike_valid) begin
                for (int n = 0; n < NUM_NEURONS; n++)
                    hist[n] <= {hist[n][T_WINDOW-2:0], spike_in[n]};
            end
            if (accept) begin
                neuron_q <= req_neuron;
                base_q   <= req_col_base;
                score_q  <= lane_score;
                mask_q   <= lane_mask;
                if (!in_range) err_neuron <= 1'b1;
            end else if (push) begin
                mask_q <= mask_clr;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= emit_entry;
    end

    assign head        = mem[rd_ptr];
    assign cand_neuron = cand_valid ? head.neuron : '0;
    assign cand_col    = cand_valid ? head.col    : '0;
    assign cand_score  = cand_valid ? head.score  : '0;
    assign fifo_count  = count;

endmodule

// File: tb/tb_tppe_multi_neuron_candidate_engine.sv
// Self-checking bench: spike-history model and expected-candidate scoreboard, plus directed
// scenarios with hand-computed literals for latency, backpressure, wrap, errors and reset.
module tb_tppe_multi_neuron_candidate_engine;
    localparam int T = 16, PF = 4, NN = 4, NW = 4, CW = 4, SW = 5, DEPTH = 8;

    typedef struct packed {
        logic [NW-1:0] neuron;
        logic [CW-1:0] col;
        logic [SW-1:0] score;
    } cand_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              spike_valid = 1'b0;
    logic [NN-1:0]     spike_in = '0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [NW-1:0]     req_neuron = '0;
    logic [CW-1:0]     req_col_base = '0;
    logic [PF*T-1:0]   req_weights = '0;
    logic [SW-1:0]     req_thresh = '0;
    logic              cand_valid;
    logic              cand_ready = 1'b1;
    logic [NW-1:0]     cand_neuron;
    logic [CW-1:0]     cand_col;
    logic [SW-1:0]     cand_score;
    logic [3:0]        fifo_count;
    logic              err_neuron;

    always #5 clk = ~clk;

    tppe_multi_neuron_candidate_engine #(
        .T_WINDOW(T), .PARALLEL_FACTOR(PF), .NUM_NEURONS(NN), .NEURON_ID_W(NW),
        .COL_ID_W(CW), .SCORE_W(SW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .spike_valid(spike_valid), .spike_in(spike_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_neuron(req_neuron),
        .req_col_base(req_col_base), .req_weights(req_weights), .req_thresh(req_thresh),
        .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_neuron(cand_neuron),
        .cand_col(cand_col), .cand_score(cand_score), .fifo_count(fifo_count),
        .err_neuron(err_neuron)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    cand_t       exp_q[$];
    cand_t       log_q[$];
    logic [T-1:0] model_hist [NN];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Scoreboard: every popped head must match the oldest outstanding expectation.
    always @(negedge clk) begin
        cand_t got;
        if (!rst && cand_valid && cand_ready) begin
            got.neuron = cand_neuron;
            got.col    = cand_col;
            got.score  = cand_score;
            if (exp_q.size() == 0) begin
                check("unexpected_cand", {19'b0, got}, 32'hFFFF_FFFF);
            end else begin
                check("cand_entry", {19'b0, got}, {19'b0, exp_q[0]});
                void'(exp_q.pop_front());
            end
            log_q.push_back(got);
        end
    end

    task automatic do_spike(input logic [NN-1:0] bits);
        spike_valid = 1'b1;
        spike_in    = bits;
        for (int n = 0; n < NN; n++) model_hist[n] = {model_hist[n][T-2:0], bits[n]};
        @(posedge clk); #1;
        spike_valid = 1'b0;
        spike_in    = '0;
    endtask

    // Drives a request until accepted, then appends the hits the model predicts.
    task automatic do_req(input int neuron, input int base, input logic [PF*T-1:0] w, input int thr);
        bit ok;
        ok = 1'b0;
        req_neuron   = NW'(neuron);
        req_col_base = CW'(base);
        req_weights  = w;
        req_thresh   = SW'(thr);
        req_valid    = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) begin
            check("req_accept", 32'(req_ready), 1);
        end else begin
            for (int j = 0; j < PF; j++) begin
                logic [T-1:0] h;
                cand_t        e;
                int           s;
                h = '0;
                if (neuron < NN) h = model_hist[neuron];
                s = $countones(h & w[j*T +: T]);
                if (s >= thr) begin
                    e.neuron = NW'(neuron);
                    e.col    = CW'((base + j) % (1 << CW));
                    e.score  = SW'(s);
                    exp_q.push_back(e);
                end
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(posedge clk);
            c++;
        end
        check(name, 32'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pat;
        logic [PF*T-1:0] all_ones;
        int c;
        pat = 16'hF0F0;
        all_ones = {PF{16'hFFFF}};
        for (int n = 0; n < NN; n++) model_hist[n] = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_cand_valid", 32'(cand_valid), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_err", 32'(err_neuron), 0);
        check("rst_cand_data", {19'b0, cand_neuron, cand_col, cand_score}, 0);
        @(posedge clk); #1;

        // n0 all ones, n1 alternating (8 ones), n2 = F0F0, n3 = zero
        for (int i = T - 1; i >= 0; i--) do_spike({1'b0, pat[i], 1'(i % 2), 1'b1});

        // Scenario 1: basic hit pattern and latency
        log_q.delete();
        do_req(2, 4, {16'h0000, 16'hFFFF, 16'h00F0, 16'hF000}, 4);
        @(negedge clk);
        check("t1_ready_c1", 32'(req_ready), 0);
        check("t1_valid_c1", 32'(cand_valid), 0);
        @(negedge clk);
        check("t1_ready_c2", 32'(req_ready), 0);
        check("t1_valid_c2", 32'(cand_valid), 1);
        @(negedge clk);
        check("t1_ready_c3", 32'(req_ready), 0);
        @(negedge clk);
        check("t1_ready_c4", 32'(req_ready), 1);
        @(posedge clk); #1;
        drain("t1_drain");
        check("t1_count", 32'(log_q.size()), 3);
        if (log_q.size() == 3) begin
            check("t1_c0", {19'b0, log_q[0]}, {19'b0, 4'd2, 4'd4, 5'd4});
            check("t1_c1", {19'b0, log_q[1]}, {19'b0, 4'd2, 4'd5, 5'd4});
            check("t1_c2", {19'b0, log_q[2]}, {19'b0, 4'd2, 4'd6, 5'd8});
        end

        // Scenario 2: consumer stalled, FIFO fills, engine stalls, then releases in order
        cand_ready = 1'b0;
        log_q.delete();
        repeat (3) do_req(0, 0, all_ones, 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t2_full_count", 32'(fifo_count), 8);
        check("t2_ready_stalled", 32'(req_ready), 0);
        check("t2_valid", 32'(cand_valid), 1);
        @(posedge clk); #1;
        cand_ready = 1'b1;
        drain("t2_drain");
        @(negedge clk);
        check("t2_empty", 32'(fifo_count), 0);
        check("t2_total", 32'(log_q.size()), 12);
        if (log_q.size() == 12)
            check("t2_last", {19'b0, log_q[11]}, {19'b0, 4'd0, 4'd3, 5'd16});
        @(posedge clk); #1;

        // Scenario 3: column wrap
        log_q.delete();
        do_req(1, 14, all_ones, 1);
        drain("t3_drain");
        check("t3_total", 32'(log_q.size()), 4);
        if (log_q.size() == 4) begin
            check("t3_col0", {19'b0, log_q[0]}, {19'b0, 4'd1, 4'd14, 5'd8});
            check("t3_col1", {19'b0, log_q[1]}, {19'b0, 4'd1, 4'd15, 5'd8});
            check("t3_col2", {19'b0, log_q[2]}, {19'b0, 4'd1, 4'd0, 5'd8});
            check("t3_col3", {19'b0, log_q[3]}, {19'b0, 4'd1, 4'd1, 5'd8});
        end

        // Scenario 4: zero history, thr=0 hits everything, thr=1 hits nothing
        log_q.delete();
        do_req(3, 0, all_ones, 0);
        drain("t4_drain");
        check("t4_total", 32'(log_q.size()), 4);
        for (int k = 0; k < log_q.size(); k++) check("t4_score0", 32'(log_q[k].score), 0);
        do_req(3, 0, all_ones, 1);
        @(negedge clk);
        check("t4_ready_next", 32'(req_ready), 1);
        check("t4_no_valid", 32'(cand_valid), 0);
        repeat (3) @(negedge clk);
        check("t4_count0", 32'(fifo_count), 0);
        @(posedge clk); #1;

        // Scenario 5: out-of-range neuron id is sticky and produces nothing
        log_q.delete();
        do_req(7, 0, all_ones, 1);
        @(negedge clk);
        check("t5_err_set", 32'(err_neuron), 1);
        check("t5_no_valid", 32'(cand_valid), 0);
        @(posedge clk); #1;
        do_req(0, 0, all_ones, 17);
        repeat (4) @(negedge clk);
        check("t5_err_sticky", 32'(err_neuron), 1);
        check("t5_no_cands", 32'(log_q.size()), 0);
        @(posedge clk); #1;

        // Scenario 6: reset during EMIT with three entries queued
        cand_ready = 1'b0;
        do_req(0, 8, all_ones, 1);
        c = 0;
        while (fifo_count != 4'd3 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("t6_reach3", 32'(fifo_count), 3);
        check("t6_in_emit", 32'(req_ready), 0);
        rst = 1'b1;
        exp_q.delete();
        for (int n = 0; n < NN; n++) model_hist[n] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", 32'(cand_valid), 0);
        check("t6_count", 32'(fifo_count), 0);
        check("t6_ready", 32'(req_ready), 1);
        check("t6_err_cleared", 32'(err_neuron), 0);
        @(posedge clk); #1;
        cand_ready = 1'b1;
        log_q.delete();
        do_req(0, 0, all_ones, 0);
        drain("t6_drain");
        check("t6_total", 32'(log_q.size()), 4);
        for (int k = 0; k < log_q.size(); k++) check("t6_hist_zero", 32'(log_q[k].score), 0);

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
